// File: rtl/mem_wb_pkg.sv
// Shared constants for the memory/write-back stage: funct3 codes, FSM encoding, datapath width.
// Also holds the address-alignment helper used when misaligned accesses are not trapped.
package mem_wb_pkg;
    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // Half accesses drop addr[0], word accesses drop addr[1:0]; bytes keep both.
    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction
endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/half lane by address and sign/zero extends it.
// Zero latency; no handshake.
module load_align
    import mem_wb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_result = i_rdata;
        case (i_funct3)
            F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_result = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_result = {24'd0, w_byte};
            F3_LHU:  o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// RV32 memory/write-back stage: runs the dmem req/gnt/rvalid handshake and drives the RF write port.
// ALU ops write 1 cycle after accept; loads write in WB. in_ready only in IDLE.
// MEM_WB_MISALIGN_TRAP_EN: misaligned half/word accesses pulse misalign_trap instead of issuing.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_load,
    input  logic               in_is_store,
    input  logic [2:0]         in_funct3,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_store_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic [3:0]         dmem_be,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               rf_wr_en,
    output logic [RADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]    rf_wr_data,
    output logic               misalign_trap
);
    logic [1:0]         r_state;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    logic [RADDR_W-1:0] r_rd;

    logic               w_accept;
    logic               w_is_mem;
    logic [1:0]         w_lo;
    logic [3:0]         w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_load_data;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;
    assign w_is_mem = in_is_load | in_is_store;
    assign w_lo     = align_lo(in_funct3, in_alu_result[1:0]);

`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic r_trap;
    logic w_misalign;
    assign w_misalign = ((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                        ((in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00));
    assign misalign_trap = r_trap;
`else
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in_store_data;
        case (in_funct3[1:0])
            F3_SB[1:0]: begin
                w_be    = 4'b0001 << w_lo;
                w_wdata = {4{in_store_data[7:0]}};
            end
            F3_SH[1:0]: begin
                w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{in_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (dmem_rdata),
        .o_result  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_funct3   <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_rd       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= 4'd0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
            r_trap     <= 1'b0;
`endif
        end else begin
            rf_wr_en <= 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
            r_trap   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_rd      <= in_rd;
                    r_funct3  <= in_funct3;
                    r_addr_lo <= w_lo;
                    if (!w_is_mem) begin
                        rf_wr_en   <= (in_rd != '0);
                        rf_wr_addr <= in_rd;
                        rf_wr_data <= in_alu_result;
                    end
`ifdef MEM_WB_MISALIGN_TRAP_EN
                    else if (w_misalign) begin
                        r_trap <= 1'b1;
                    end
`endif
                    else begin
                        r_state    <= ST_REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= in_is_store;
                        dmem_addr  <= {in_alu_result[XLEN-1:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= in_is_store ? w_wdata : '0;
                    end
                end
                ST_REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    if (dmem_we) begin
                        r_state <= ST_IDLE;
                    end else if (dmem_rvalid) begin
                        r_state    <= ST_WB;
                        rf_wr_en   <= (r_rd != '0);
                        rf_wr_addr <= r_rd;
                        rf_wr_data <= w_load_data;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (dmem_rvalid) begin
                    r_state    <= ST_WB;
                    rf_wr_en   <= (r_rd != '0);
                    rf_wr_addr <= r_rd;
                    rf_wr_data <= w_load_data;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
